// File: rtl/nibble_serializer.sv
// Serializes one 32-bit word into 8 nibbles (slot 0 = MS nibble), each tagged with its slot index.
// Handshaked on both sides; back-to-back words stream with no idle beat between them.
module nibble_serializer #(
  parameter int DATA_W   = 4,
  parameter int NB_SLOTS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                         inClk,
  input  logic                         inReset,
  input  logic [DATA_W*NB_SLOTS-1:0]   inData,
  input  logic                         inValid,
  output logic                         outReady,
  output logic [DATA_W-1:0]            outData,
  output logic [SEL_W-1:0]             outSel,
  output logic                         outValid,
  output logic                         outLast,
  input  logic                         inReady
);

  localparam int WORD_W = DATA_W * NB_SLOTS;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NB_SLOTS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [SEL_W-1:0]    cnt_q;
  logic [SEL_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                last_q;
  logic                last_beat;
  logic                accept;
  logic [DATA_W-1:0]   word_nib [NB_SLOTS];

  // Slot k lives in the k-th nibble counting down from the MSB.
  for (genvar gi = 0; gi < NB_SLOTS; gi++) begin : g_nib
    assign word_nib[gi] = word_q[(NB_SLOTS-gi)*DATA_W-1 -: DATA_W];
  end

  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = (state_q == SEND) && (cnt_q == LAST_SEL) && inReady;
  // Ready opens during the completing last beat so the next word loads without a bubble.
  assign outReady  = !inReset && ((state_q == IDLE) || last_beat);
  assign accept    = inValid && outReady;

  always_ff @(posedge inClk) begin
    if (inReset) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SEND;
            word_q  <= inData;
            cnt_q   <= '0;
            data_q  <= inData[WORD_W-1 -: DATA_W];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        SEND: begin
          if (accept) begin
            word_q  <= inData;
            cnt_q   <= '0;
            data_q  <= inData[WORD_W-1 -: DATA_W];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end else if (last_beat) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (inReady) begin
            cnt_q  <= cnt_d;
            data_q <= word_nib[cnt_d];
            last_q <= (cnt_d == LAST_SEL);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outData  = data_q;
  assign outSel   = cnt_q;
  assign outValid = valid_q;
  assign outLast  = last_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: inputs driven and outputs sampled on the falling edge.
module tb_nibble_serializer;

  logic        inClk = 1'b0;
  logic        inReset;
  logic [31:0] inData;
  logic        inValid;
  logic        outReady;
  logic [3:0]  outData;
  logic [2:0]  outSel;
  logic        outValid;
  logic        outLast;
  logic        inReady;

  int checks = 0;
  int errors = 0;

  always #5 inClk = ~inClk;

  nibble_serializer #(.DATA_W(4), .NB_SLOTS(8), .SEL_W(3)) dut (
    .inClk   (inClk),
    .inReset (inReset),
    .inData  (inData),
    .inValid (inValid),
    .outReady(outReady),
    .outData (outData),
    .outSel  (outSel),
    .outValid(outValid),
    .outLast (outLast),
    .inReady (inReady)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a word while idle; it must be taken on the next rising edge.
  task automatic accept_word(input logic [31:0] w);
    @(negedge inClk);
    inValid = 1'b1;
    inData  = w;
    #1;
    chk("accept_ready", {31'b0, outReady}, 32'd1);
    @(posedge inClk);
    #1;
    inValid = 1'b0;
    inData  = 32'hFFFF_FFFF;
  endtask

  // Walk nbeats slots of word w. mode 0: ready always, 1: ready 1,0,0,1 pattern, 2: random.
  // On the completing last beat, inValid/inData are driven with nv/nd (back-to-back load).
  task automatic run_beats(input logic [31:0] w, input int nbeats, input int mode,
                           input logic nv, input logic [31:0] nd);
    int k = 0;
    int cyc = 0;
    logic rdy;
    logic [31:0] re = '0;
    logic [3:0] exp_nib;
    while (k < nbeats && cyc < 400) begin
      @(negedge inClk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      inReady = rdy;
      if (k == 7 && rdy) begin
        inValid = nv;
        inData  = nd;
      end else begin
        inValid = 1'b0;
        inData  = 32'hFFFF_FFFF;
      end
      #1;
      exp_nib = w[31-4*k -: 4];
      chk("valid", {31'b0, outValid}, 32'd1);
      chk("data",  {28'b0, outData}, {28'b0, exp_nib});
      chk("sel",   {29'b0, outSel}, k);
      chk("last",  {31'b0, outLast}, {31'b0, (k == 7)});
      chk("ready", {31'b0, outReady}, {31'b0, (k == 7) && rdy});
      if (rdy) re[31-4*outSel -: 4] = outData;
      @(posedge inClk);
      if (rdy) k++;
      cyc++;
    end
    if (k < nbeats) chk("beat_timeout", k, nbeats);
    if (nbeats == 8) chk("reassembled", re, w);
    #1;
    inValid = 1'b0;
    inData  = 32'hFFFF_FFFF;
  endtask

  task automatic check_idle();
    @(negedge inClk);
    #1;
    chk("idle_valid", {31'b0, outValid}, 32'd0);
    chk("idle_ready", {31'b0, outReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] rw;
    inReset = 1'b1;
    inData  = 32'h0;
    inValid = 1'b0;
    inReady = 1'b0;
    repeat (2) @(posedge inClk);
    @(negedge inClk);
    chk("rst_ready",  {31'b0, outReady}, 32'd0);
    chk("rst_valid",  {31'b0, outValid}, 32'd0);
    chk("rst_data",   {28'b0, outData}, 32'd0);
    chk("rst_sel",    {29'b0, outSel}, 32'd0);
    chk("rst_last",   {31'b0, outLast}, 32'd0);
    inReset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, outReady}, 32'd1);
    $display("step: basic word 1234ABCD");

    accept_word(32'h1234_ABCD);
    run_beats(32'h1234_ABCD, 8, 0, 1'b0, 32'h0);
    check_idle();
    $display("step: stalled word 1234ABCD");

    accept_word(32'h1234_ABCD);
    run_beats(32'h1234_ABCD, 8, 1, 1'b0, 32'h0);
    check_idle();
    $display("step: back-to-back FEDCBA98 / 01234567");

    accept_word(32'hFEDC_BA98);
    run_beats(32'hFEDC_BA98, 8, 0, 1'b1, 32'h0123_4567);
    run_beats(32'h0123_4567, 8, 0, 1'b0, 32'h0);
    check_idle();
    $display("step: reset mid-word CAFEF00D");

    accept_word(32'hCAFE_F00D);
    run_beats(32'hCAFE_F00D, 3, 0, 1'b0, 32'h0);
    @(negedge inClk);
    inReset = 1'b1;
    @(posedge inClk);
    @(negedge inClk);
    chk("midrst_valid", {31'b0, outValid}, 32'd0);
    chk("midrst_sel",   {29'b0, outSel}, 32'd0);
    chk("midrst_data",  {28'b0, outData}, 32'd0);
    chk("midrst_ready", {31'b0, outReady}, 32'd0);
    inReset = 1'b0;
    accept_word(32'h0000_0005);
    run_beats(32'h0000_0005, 8, 0, 1'b0, 32'h0);
    check_idle();
    $display("step: input change ignored on 11111111");

    accept_word(32'h1111_1111);
    run_beats(32'h1111_1111, 8, 1, 1'b0, 32'h0);
    check_idle();
    $display("step: 1000 random loopback words");

    for (int i = 0; i < 1000; i++) begin
      rw = $urandom;
      accept_word(rw);
      run_beats(rw, 8, 2, 1'b0, 32'h0);
    end
    check_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
- Reader-side counterpart of the DEMUX184 4-bit 1:8 demultiplexer.
- Accepts one 32-bit word over a valid/ready handshake and emits it as 8 nibbles, one per accepted beat, each tagged with its 3-bit slot index.
- Driving a DEMUX184 with outData/outSel reproduces the original word slot by slot.
- Sits between the chip/symbol word source and nibble-wide processing in the Zigbee TX/RX datapath.

Parameters:
- DATA_W, 4, nibble width in bits.
- NB_SLOTS, 8, nibbles per word.
- SEL_W, 3, slot index width (log2 of NB_SLOTS).

Ports:
- inClk  input  1  rising-edge clock.
- inReset  input  1  synchronous reset, active-high.
- inData  input  32  word to serialize. Slot k occupies bits [31-4k : 28-4k].
- inValid  input  1  inData is valid.
- outReady  output  1  block can accept a word this cycle.
- outData  output  4  current nibble.
- outSel  output  3  slot index of the current nibble (0..7).
- outValid  output  1  outData/outSel are valid.
- outLast  output  1  current nibble is slot 7.
- inReady  input  1  downstream accepts the current nibble.

Behaviour:
- Reset (inReset=1 at a rising edge):
  - Outputs next cycle: state=IDLE, outValid=0, outData=0, outSel=0, outLast=0.
  - The word register and slot counter are cleared.
  - outReady=0 while inReset is high.
  - Reset mid-word discards the remaining nibbles; no partial continuation.
- States: IDLE, SEND.
- IDLE:
  - outReady=1, outValid=0.
  - On inValid=1 at an edge: latch inData, set counter=0, go to SEND.
- SEND:
  - outValid=1, outSel=counter, outData=word[31-4*counter : 28-4*counter], outLast=(counter==7).
- Beat handshake:
  - A beat completes when outValid && inReady at an edge; the counter then increments.
  - If inReady=0, outData/outSel/outLast hold stable. No nibble is skipped or repeated.
- Last beat (counter==7 and inReady=1):
  - outReady=1 in that same cycle, combinationally from inReady.
  - If inValid=1 too, the new word is latched, counter wraps to 0, and the state stays SEND: back-to-back, zero bubbles.
  - Otherwise go to IDLE.
- outReady=0 in SEND except during that last-beat cycle.
- inData changes while outReady=0 are ignored; the latched word is the only source.
- Latency: word accepted at edge N → slot 0 valid in cycle N+1. A full word takes 8 beat-cycles at inReady=1, for 8 cycles per word sustained.
- Counter is SEL_W bits; it wraps 7→0 only on last-beat completion.
- Outputs are registered except outReady. outReady depends on state and on inReady during the last beat.

Test Plan:
- Reset then accept 0x1234ABCD with inReady=1 → outValid rises next cycle. outData sequence 1,2,3,4,A,B,C,D with outSel 0..7; outLast only on 0xD. Back to IDLE, outReady=1 after 8 beats.
- Same word with inReady toggling 1,0,0,1,… → each nibble held stable while inReady=0. Full sequence unchanged, no duplicates; total cycles = 8 + stall cycles.
- Back-to-back words 0xFEDCBA98 then 0x01234567, inValid held high → 16 consecutive valid beats, no gap. outReady=1 only at accept and on each outLast cycle.
- Assert inReset at beat 3 of 0xCAFEF00D → next cycle outValid=0, outSel=0. Following word 0x00000005 emits 0,0,0,0,0,0,0,5 from slot 0.
- Change inData to 0xFFFFFFFF mid-word of 0x11111111 → output stays all 1s.
- Loopback: outData/outSel into DEMUX184, capturing each slot on a handshake, for 1000 random words with random inReady → reassembled word equals input word.
